// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: moves the operand at most STEP bit positions per clock
// and reports the finished value with a one-cycle done pulse.
module seq_shifter #(
  parameter  int XLEN = 32,
  parameter  int STEP = 1,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [SHW-1:0]  shamt,
  input  logic [2:0]      op,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [SHW:0] STEP_C = (SHW+1)'(STEP);
  localparam logic [SHW:0] XLEN_C = (SHW+1)'(XLEN);

  state_t          r_state;
  logic [XLEN-1:0] r_data;
  logic [SHW:0]    r_cnt;
  logic [2:0]      r_op;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  logic [SHW:0]    w_k;
  logic [SHW:0]    w_ror_amt;
  logic [XLEN-1:0] w_rot;
  logic [XLEN-1:0] w_shr;
  logic [XLEN-1:0] w_next;

  // NOTE: every variable written in always_comb gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_k       = (r_cnt < STEP_C) ? r_cnt : STEP_C;
    // A left rotate by k is a right rotate by XLEN-k; both share one rotator.
    w_ror_amt = r_op[0] ? w_k : (XLEN_C - w_k);
    w_rot     = (r_data >> w_ror_amt) | (r_data << (XLEN_C - w_ror_amt));
    // SRA keeps the MSB fixed, so r_data[XLEN-1] is still the sign latched at start.
    w_shr     = r_op[1] ? $unsigned($signed(r_data) >>> w_k) : (r_data >> w_k);
    w_next    = r_data;
    if (r_op[2]) begin
      w_next = w_rot;
    end else if (r_op[0]) begin
      w_next = w_shr;
    end else begin
      w_next = r_data << w_k;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_data   <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_data  <= a;
            r_cnt   <= {1'b0, shamt};
            r_op    <= op;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_data <= w_next;
          r_cnt  <= r_cnt - w_k;
          if (r_cnt <= STEP_C) begin
            r_result <= w_next;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: three builds (STEP=1, 4, 32) share one stimulus and are
// checked for result, latency, busy width and done pulses against hand-derived values.
module tb_seq_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic [2:0]  op;

  logic        busy1, done1, busy4, done4, busy32, done32;
  logic [31:0] res1, res4, res32;

  int n_tests = 0;
  int n_fail  = 0;
  int d1, d4, d32;

  seq_shifter #(.XLEN(32), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start), .a(a), .shamt(shamt), .op(op),
    .busy(busy1), .done(done1), .result(res1)
  );
  seq_shifter #(.XLEN(32), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .start(start), .a(a), .shamt(shamt), .op(op),
    .busy(busy4), .done(done4), .result(res4)
  );
  seq_shifter #(.XLEN(32), .STEP(32)) u_s32 (
    .clk(clk), .rst(rst), .start(start), .a(a), .shamt(shamt), .op(op),
    .busy(busy32), .done(done32), .result(res32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Bit-by-bit reference: result bit i is taken from the source position it came from.
  function automatic logic [31:0] ref_shift(input logic [31:0] ra, input logic [4:0] rsh,
                                            input logic [2:0] rop);
    logic [31:0] r;
    int sh;
    int src;
    sh = int'(rsh);
    r  = '0;
    for (int i = 0; i < 32; i++) begin
      if (rop[2]) begin
        src = rop[0] ? (i + sh) % 32 : (i - sh + 32) % 32;
        r[i] = ra[src];
      end else if (rop[0]) begin
        src  = i + sh;
        r[i] = (src < 32) ? ra[src] : (rop[1] & ra[31]);
      end else begin
        src  = i - sh;
        r[i] = (src >= 0) ? ra[src] : 1'b0;
      end
    end
    return r;
  endfunction

  // Issue one operation from idle, scramble the inputs while busy, then watch 40 cycles.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [4:0] tsh,
                        input logic [2:0] top, input logic [31:0] exp_r);
    int e1, e4;
    int n1, n4, n32, c1, c4, c32, b1;
    e1 = (tsh == 0) ? 1 : int'(tsh);
    e4 = (tsh == 0) ? 1 : (int'(tsh) + 3) / 4;
    a = ta; shamt = tsh; op = top; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; shamt = ~tsh; op = ~top;
    check({tag, " busy1"},  32'(busy1),  32'd1);
    check({tag, " busy4"},  32'(busy4),  32'd1);
    check({tag, " busy32"}, 32'(busy32), 32'd1);
    n1 = -1; n4 = -1; n32 = -1; c1 = 0; c4 = 0; c32 = 0; b1 = 1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy1)  b1++;
      if (done1)  begin c1++;  n1  = n; end
      if (done4)  begin c4++;  n4  = n; end
      if (done32) begin c32++; n32 = n; end
    end
    check({tag, " lat1"},   n1,  e1);
    check({tag, " lat4"},   n4,  e4);
    check({tag, " lat32"},  n32, 1);
    check({tag, " dones1"}, c1,  1);
    check({tag, " dones4"}, c4,  1);
    check({tag, " dones32"}, c32, 1);
    check({tag, " busycyc1"}, b1, e1);
    check({tag, " res1"},  res1,  exp_r);
    check({tag, " res4"},  res4,  exp_r);
    check({tag, " res32"}, res32, exp_r);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; shamt = '0; op = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst busy1",  32'(busy1),  32'd0);
    check("rst done1",  32'(done1),  32'd0);
    check("rst res1",   res1,        32'd0);
    check("rst busy4",  32'(busy4),  32'd0);
    check("rst res4",   res4,        32'd0);
    check("rst busy32", 32'(busy32), 32'd0);
    check("rst res32",  res32,       32'd0);

    run_op("sll4",     32'h0000_00FF, 5'd4,  3'b000, 32'h0000_0FF0);
    run_op("sra31",    32'h8000_0000, 5'd31, 3'b011, 32'hFFFF_FFFF);
    run_op("srl31",    32'h8000_0000, 5'd31, 3'b001, 32'h0000_0001);
    run_op("rol8",     32'h1234_5678, 5'd8,  3'b100, 32'h3456_7812);
    run_op("ror8",     32'h1234_5678, 5'd8,  3'b101, 32'h7812_3456);
    run_op("sll31",    32'h1234_5678, 5'd31, 3'b000, 32'h0000_0000);
    run_op("ror0",     32'hDEAD_BEEF, 5'd0,  3'b101, 32'hDEAD_BEEF);
    run_op("sra6",     32'hF0F0_0000, 5'd6,  3'b011, 32'hFFC3_C000);
    run_op("sra_pos",  32'h7000_0000, 5'd4,  3'b011, 32'h0700_0000);
    run_op("op010",    32'h0000_0001, 5'd3,  3'b010, 32'h0000_0008);
    run_op("op111",    32'h0000_0001, 5'd1,  3'b111, 32'h8000_0000);
    run_op("op110",    32'h8000_0001, 5'd4,  3'b110, 32'h0000_0018);

    // start held high: each build accepts only while idle, including the done cycle.
    a = 32'h0000_0005; shamt = 5'd3; op = 3'b000; start = 1'b1;
    d1 = 0; d4 = 0; d32 = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (done1) begin
        d1++;
        check("hold res1", res1, 32'h0000_0028);
      end
      if (done4)  d4++;
      if (done32) d32++;
    end
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("hold dones1",  d1,  4);
    check("hold dones4",  d4,  8);
    check("hold dones32", d32, 8);
    check("hold res32",   res32, 32'h0000_0028);

    // Back-to-back single-step build against the reference model.
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra;
      logic [4:0]  rsh;
      logic [2:0]  rop;
      ra  = $urandom;
      rsh = 5'($urandom_range(31, 0));
      rop = 3'($urandom_range(7, 0));
      a = ra; shamt = rsh; op = rop; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = $urandom; shamt = 5'($urandom_range(31, 0)); op = 3'($urandom_range(7, 0));
      @(negedge clk);
      check("rand done32", 32'(done32), 32'd1);
      check("rand res32",  res32, ref_shift(ra, rsh, rop));
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    // Reset in the middle of a long operation aborts it with no done pulse.
    a = 32'h0000_FFFF; shamt = 5'd20; op = 3'b000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d1 = 0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (done1) d1++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid busy1",  32'(busy1), 32'd0);
    check("mid done1",  32'(done1), 32'd0);
    check("mid res1",   res1,  32'd0);
    check("mid busy4",  32'(busy4), 32'd0);
    check("mid res4",   res4,  32'd0);
    check("mid res32",  res32, 32'd0);
    d4 = 0; d32 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done1)  d1++;
      if (done4)  d4++;
      if (done32) d32++;
    end
    check("mid nodone1",  d1,  0);
    check("mid nodone4",  d4,  0);
    check("mid nodone32", d32, 0);
    run_op("post_rst", 32'h0000_FFFF, 5'd20, 3'b000, 32'hFFF0_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
